// File: rtl/ss_display_reader.sv
// Recovers mode, sign and 16-bit hex value from a 7-segment display bundle, once the reading is stable.
// Defining SS_READER_DELTA_EN adds a signed delta output between successive locked readings.
module ss_display_reader #(
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned CNT_W          = 4
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        sample,
  input  logic [6:0]  ss7,
  input  logic [6:0]  ss6,
  input  logic [6:0]  ss5,
  input  logic [6:0]  ss3,
  input  logic [6:0]  ss2,
  input  logic [6:0]  ss1,
  input  logic [6:0]  ss0,
  output logic [1:0]  mode,
  output logic [15:0] value,
  output logic        neg,
  output logic        valid,
  output logic        upd,
  output logic        glyph_err
`ifdef SS_READER_DELTA_EN
  ,
  output logic [16:0] delta
`endif
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [1:0]       ModeAlt = 2'd0;
  localparam logic [1:0]       ModeVel = 2'd1;
  localparam logic [1:0]       ModeGas = 2'd2;
  localparam logic [1:0]       ModeThr = 2'd3;
  localparam logic [6:0]       GlyphBlank = 7'h00;
  localparam logic [6:0]       GlyphMinus = 7'h40;

  typedef enum logic [1:0] {StEmpty, StSettle, StLocked, StFault} state_e;

  // Returns {legal, nibble} for a hex-digit glyph.
  function automatic logic [4:0] hex_dec(input logic [6:0] g);
    logic [4:0] r;
    r = 5'b0_0000;
    case (g)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h67: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [16:0] to_signed17(input logic n, input logic [15:0] v);
    return n ? -{1'b0, v} : {1'b0, v};
  endfunction

  // Combinational decode of the sampled bundle
  logic [1:0]  dec_mode;
  logic        label_ok;
  logic        dec_neg;
  logic        dig_ok;
  logic        lead;
  logic [15:0] dec_value;
  logic [4:0]  h3, h2, h1, h0;
  logic        dec_bad;
  logic [18:0] dec_key;

  always_comb begin
    dec_mode = ModeAlt;
    label_ok = 1'b1;
    case ({ss7, ss6, ss5})
      {7'h77, 7'h38, 7'h78}: dec_mode = ModeAlt;
      {7'h3E, 7'h79, 7'h38}: dec_mode = ModeVel;
      {7'h6F, 7'h77, 7'h6D}: dec_mode = ModeGas;
      {7'h78, 7'h76, 7'h50}: dec_mode = ModeThr;
      default:               label_ok = 1'b0;
    endcase
  end

  assign h3 = hex_dec(ss3);
  assign h2 = hex_dec(ss2);
  assign h1 = hex_dec(ss1);
  assign h0 = hex_dec(ss0);

  // A blank is a leading zero only while no digit has appeared to its left; a leading '-' does
  // not end the leading region.
  always_comb begin
    dec_neg   = 1'b0;
    dig_ok    = 1'b1;
    lead      = 1'b1;
    dec_value = 16'h0000;

    if (ss3 == GlyphMinus) begin
      dec_neg = 1'b1;
      if (!(label_ok && dec_mode == ModeVel)) dig_ok = 1'b0;
    end else if (ss3 != GlyphBlank) begin
      lead              = 1'b0;
      dig_ok            = dig_ok & h3[4];
      dec_value[15:12]  = h3[3:0];
    end

    if (ss2 == GlyphBlank) begin
      if (!lead) dig_ok = 1'b0;
    end else begin
      lead             = 1'b0;
      dig_ok           = dig_ok & h2[4];
      dec_value[11:8]  = h2[3:0];
    end

    if (ss1 == GlyphBlank) begin
      if (!lead) dig_ok = 1'b0;
    end else begin
      lead            = 1'b0;
      dig_ok          = dig_ok & h1[4];
      dec_value[7:4]  = h1[3:0];
    end

    dig_ok          = dig_ok & h0[4];
    dec_value[3:0]  = h0[3:0];
  end

  assign dec_bad = !(label_ok && dig_ok);
  assign dec_key = {dec_mode, dec_neg, dec_value};

  // Sequential state
  state_e            state_q, state_d;
  logic [18:0]       cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       value_q, value_d;
  logic              neg_q, neg_d;
  logic              valid_q, valid_d;
  logic              upd_q, upd_d;
  logic              glyph_err_q, glyph_err_d;
  logic [16:0]       delta_q, delta_d;
  logic              fresh;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    value_d     = value_q;
    neg_d       = neg_q;
    valid_d     = valid_q;
    delta_d     = delta_q;
    upd_d       = 1'b0;
    glyph_err_d = 1'b0;
    fresh       = 1'b0;

    if (sample) begin
      if (dec_bad) begin
        glyph_err_d = 1'b1;
        valid_d     = 1'b0;
        cnt_d       = '0;
        state_d     = StFault;
      end else begin
        // After reset or a fault the stored candidate is stale, so always restart settling.
        fresh = (state_q == StEmpty) || (state_q == StFault) || (dec_key != cand_q);
        if (fresh) begin
          cand_d  = dec_key;
          cnt_d   = '0;
          state_d = StSettle;
        end else if (cnt_q != LastCnt) begin
          cnt_d = cnt_q + 1'b1;
        end

        if ((cnt_d == LastCnt) && (state_d != StLocked)) begin
          mode_d  = cand_d[18:17];
          neg_d   = cand_d[16];
          value_d = cand_d[15:0];
          valid_d = 1'b1;
          upd_d   = 1'b1;
          state_d = StLocked;
          if (valid_q && (cand_d[18:17] == mode_q)) begin
            delta_d = to_signed17(cand_d[16], cand_d[15:0]) - to_signed17(neg_q, value_q);
          end else begin
            delta_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      cand_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= ModeAlt;
      value_q     <= '0;
      neg_q       <= 1'b0;
      valid_q     <= 1'b0;
      upd_q       <= 1'b0;
      glyph_err_q <= 1'b0;
      delta_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      neg_q       <= neg_d;
      valid_q     <= valid_d;
      upd_q       <= upd_d;
      glyph_err_q <= glyph_err_d;
      delta_q     <= delta_d;
    end
  end

  assign mode      = mode_q;
  assign value     = value_q;
  assign neg       = neg_q;
  assign valid     = valid_q;
  assign upd       = upd_q;
  assign glyph_err = glyph_err_q;

`ifdef SS_READER_DELTA_EN
  assign delta = delta_q;
`else
  logic unused_delta;
  assign unused_delta = ^{delta_q, delta_d, ModeGas, ModeThr};
`endif

endmodule

// File: tb/tb_ss_display_reader.sv
// Directed self-checking bench for ss_display_reader (default STABLE_SAMPLES = 3).
module tb_ss_display_reader;

  logic        hz100;
  logic        reset;
  logic        sample;
  logic [6:0]  ss7, ss6, ss5, ss3, ss2, ss1, ss0;
  logic [1:0]  mode;
  logic [15:0] value;
  logic        neg;
  logic        valid;
  logic        upd;
  logic        glyph_err;
`ifdef SS_READER_DELTA_EN
  logic [16:0] delta;
`endif

  int checks = 0;
  int errors = 0;

  ss_display_reader dut (
    .hz100     (hz100),
    .reset     (reset),
    .sample    (sample),
    .ss7       (ss7),
    .ss6       (ss6),
    .ss5       (ss5),
    .ss3       (ss3),
    .ss2       (ss2),
    .ss1       (ss1),
    .ss0       (ss0),
    .mode      (mode),
    .value     (value),
    .neg       (neg),
    .valid     (valid),
    .upd       (upd),
    .glyph_err (glyph_err)
`ifdef SS_READER_DELTA_EN
    ,
    .delta     (delta)
`endif
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [6:0] l7, input logic [6:0] l6, input logic [6:0] l5,
                        input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1,
                        input logic [6:0] d0);
    ss7 = l7; ss6 = l6; ss5 = l5;
    ss3 = d3; ss2 = d2; ss1 = d1; ss0 = d0;
  endtask

  // Called at a falling edge; returns at the next falling edge with the strobe's result visible.
  task automatic strobe();
    sample = 1'b1;
    @(negedge hz100);
    sample = 1'b0;
  endtask

  task automatic tick();
    @(negedge hz100);
  endtask

  initial begin
    reset  = 1'b0;
    sample = 1'b0;
    bundle(7'h77, 7'h38, 7'h78, 7'h66, 7'h6D, 7'h3F, 7'h3F);

    // 1: reset held for 5 cycles, strobes ignored meanwhile
    repeat (2) tick();
    sample = 1'b1;
    repeat (3) tick();
    sample = 1'b0;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_gerr", 32'(glyph_err), 32'd0);
    reset = 1'b1;
    tick();

    // 2: ALT 4500 locks on the third strobe
    strobe();
    check("alt_s1_upd", 32'(upd), 32'd0);
    check("alt_s1_valid", 32'(valid), 32'd0);
    tick();
    strobe();
    check("alt_s2_upd", 32'(upd), 32'd0);
    tick();
    strobe();
    check("alt_s3_upd", 32'(upd), 32'd1);
    check("alt_s3_valid", 32'(valid), 32'd1);
    check("alt_s3_mode", 32'(mode), 32'd0);
    check("alt_s3_value", 32'(value), 32'h4500);
    check("alt_s3_neg", 32'(neg), 32'd0);
`ifdef SS_READER_DELTA_EN
    check("alt_delta_first", 32'(delta), 32'h0);
`endif
    tick();
    check("alt_upd_pulse", 32'(upd), 32'd0);
    // Non-strobe cycles with a different bundle change nothing
    bundle(7'h3E, 7'h79, 7'h38, 7'h40, 7'h00, 7'h5B, 7'h7D);
    repeat (3) tick();
    check("hold_value", 32'(value), 32'h4500);
    check("hold_mode", 32'(mode), 32'd0);
    bundle(7'h77, 7'h38, 7'h78, 7'h66, 7'h6D, 7'h3F, 7'h3F);
    strobe();
    check("alt_s4_upd", 32'(upd), 32'd0);
    check("alt_s4_valid", 32'(valid), 32'd1);
    tick();

    // 3: VEL -26 settles while the ALT reading remains held
    bundle(7'h3E, 7'h79, 7'h38, 7'h40, 7'h00, 7'h5B, 7'h7D);
    strobe();
    check("vel_s1_valid", 32'(valid), 32'd1);
    check("vel_s1_value", 32'(value), 32'h4500);
    check("vel_s1_upd", 32'(upd), 32'd0);
    tick();
    strobe();
    check("vel_s2_value", 32'(value), 32'h4500);
    tick();
    strobe();
    check("vel_s3_upd", 32'(upd), 32'd1);
    check("vel_s3_mode", 32'(mode), 32'd1);
    check("vel_s3_neg", 32'(neg), 32'd1);
    check("vel_s3_value", 32'(value), 32'h0026);
`ifdef SS_READER_DELTA_EN
    check("vel_delta_modechg", 32'(delta), 32'h0);
`endif
    tick();

    // 4: illegal glyph, then GAS 0
    bundle(7'h6F, 7'h77, 7'h6D, 7'h00, 7'h5B, 7'h01, 7'h3F);
    strobe();
    check("gas_bad_gerr", 32'(glyph_err), 32'd1);
    check("gas_bad_valid", 32'(valid), 32'd0);
    check("gas_bad_upd", 32'(upd), 32'd0);
    tick();
    check("gas_gerr_pulse", 32'(glyph_err), 32'd0);
    bundle(7'h6F, 7'h77, 7'h6D, 7'h00, 7'h00, 7'h00, 7'h3F);
    strobe();
    check("gas_s1_valid", 32'(valid), 32'd0);
    tick();
    strobe();
    check("gas_s2_upd", 32'(upd), 32'd0);
    tick();
    strobe();
    check("gas_s3_upd", 32'(upd), 32'd1);
    check("gas_s3_gerr", 32'(glyph_err), 32'd0);
    check("gas_s3_mode", 32'(mode), 32'd2);
    check("gas_s3_value", 32'(value), 32'h0);
    check("gas_s3_valid", 32'(valid), 32'd1);
    tick();

    // 5: interior blank, minus with THR, blank units digit, unknown label
    bundle(7'h77, 7'h38, 7'h78, 7'h66, 7'h00, 7'h3F, 7'h3F);
    strobe();
    check("interior_blank_gerr", 32'(glyph_err), 32'd1);
    check("interior_blank_valid", 32'(valid), 32'd0);
    tick();
    bundle(7'h78, 7'h76, 7'h50, 7'h40, 7'h00, 7'h00, 7'h3F);
    strobe();
    check("thr_minus_gerr", 32'(glyph_err), 32'd1);
    tick();
    bundle(7'h77, 7'h38, 7'h78, 7'h00, 7'h00, 7'h00, 7'h00);
    strobe();
    check("blank_ss0_gerr", 32'(glyph_err), 32'd1);
    tick();
    bundle(7'h77, 7'h77, 7'h78, 7'h00, 7'h00, 7'h00, 7'h3F);
    strobe();
    check("bad_label_gerr", 32'(glyph_err), 32'd1);
    tick();
    // THR F00d is legal with all four digits
    bundle(7'h78, 7'h76, 7'h50, 7'h71, 7'h3F, 7'h3F, 7'h5E);
    repeat (2) begin
      strobe();
      tick();
    end
    strobe();
    check("thr_upd", 32'(upd), 32'd1);
    check("thr_mode", 32'(mode), 32'd3);
    check("thr_value", 32'(value), 32'hF00D);
    tick();

    // 6: reset mid-settle discards progress
    bundle(7'h77, 7'h38, 7'h78, 7'h66, 7'h6D, 7'h3F, 7'h3F);
    strobe();
    tick();
    strobe();
    check("pre_rst_upd", 32'(upd), 32'd0);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_value", 32'(value), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    strobe();
    check("post_rst_s1_upd", 32'(upd), 32'd0);
    check("post_rst_s1_valid", 32'(valid), 32'd0);
    tick();
    strobe();
    tick();
    strobe();
    check("post_rst_s3_upd", 32'(upd), 32'd1);
    check("post_rst_s3_value", 32'(value), 32'h4500);
    tick();

    // Signed delta between two negative VEL readings
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bundle(7'h3E, 7'h79, 7'h38, 7'h40, 7'h00, 7'h4F, 7'h3F);
    repeat (2) begin
      strobe();
      tick();
    end
    strobe();
    check("vel30_value", 32'(value), 32'h0030);
`ifdef SS_READER_DELTA_EN
    check("vel30_delta", 32'(delta), 32'h0);
`endif
    tick();
    bundle(7'h3E, 7'h79, 7'h38, 7'h40, 7'h00, 7'h5B, 7'h7D);
    repeat (2) begin
      strobe();
      tick();
    end
    strobe();
    check("vel26_upd", 32'(upd), 32'd1);
    check("vel26_value", 32'(value), 32'h0026);
    check("vel26_neg", 32'(neg), 32'd1);
`ifdef SS_READER_DELTA_EN
    check("vel26_delta", 32'(delta), 32'h0000A);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
